// File: rtl/md_pkg.sv
// md_pkg: operation encodings and default latencies for the multiply/divide scheduler
package md_pkg;
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic is_arith(input md_op_t op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction
endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E/D-stage request and HI/LO result bundle between the pipeline and md_sched
interface md_sched_if;
    logic        md_valid_E;
    logic [2:0]  md_op_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_valid_E, md_op_E, rs_val_E, rt_val_E, md_use_D,
        input  busy, stall_md, hi, lo
    );
    modport slave (
        input  md_valid_E, md_op_E, rs_val_E, rt_val_E, md_use_D,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath returning {hi,lo} and a write enable
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        we
);
    logic        sgn, neg;
    logic [31:0] ma, mb, q, r;
    logic [63:0] prod;

    // Signed ops run on magnitudes so MIN/-1 wraps cleanly instead of overflowing.
    always_comb begin
        sgn  = op inside {MD_MULT, MD_DIV};
        neg  = sgn && (a[31] ^ b[31]);
        ma   = (sgn && a[31]) ? -a : a;
        mb   = (sgn && b[31]) ? -b : b;
        prod = {32'd0, ma} * {32'd0, mb};
        q    = (mb == 32'd0) ? 32'd0 : ma / mb;
        r    = (mb == 32'd0) ? 32'd0 : ma % mb;
        res  = (op inside {MD_MULT, MD_MULTU}) ? (neg ? -prod : prod)
                                               : {(sgn && a[31]) ? -r : r, neg ? -q : q};
        we   = (op inside {MD_MULT, MD_MULTU}) || ((op inside {MD_DIV, MD_DIVU}) && b != 32'd0);
    end
endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO and raising the D-stage stall
// MD_FLUSH_EN adds md_flush, which abandons the in-flight op and any same-cycle HI/LO update.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic       clk,
    input logic       reset,
    md_sched_if.slave bus
`ifdef MD_FLUSH_EN
    ,
    input logic       md_flush
`endif
);
    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    logic [CW-1:0] cnt, cnt_nxt;
    md_op_t        op_in, op_r;
    logic [31:0]   op_a, op_b, hi, lo, hi_nxt, lo_nxt;
    logic [63:0]   res;
    logic          flush, idle, start, mt, done, we;

`ifdef MD_FLUSH_EN
    assign flush = md_flush;
`else
    assign flush = 1'b0;
`endif

    assign op_in = md_op_t'(bus.md_op_E);
    assign idle  = cnt == '0;
    assign start = bus.md_valid_E && idle && is_arith(op_in);
    assign mt    = bus.md_valid_E && idle && !flush && (op_in inside {MD_MTHI, MD_MTLO});
    assign done  = cnt == CW'(1);

    md_arith u_arith (
        .op  (op_r),
        .a   (op_a),
        .b   (op_b),
        .res (res),
        .we  (we)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            op_r <= MD_NONE;
            op_a <= '0;
            op_b <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            cnt <= cnt_nxt;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            if (start && !flush) begin
                op_r <= op_in;
                op_a <= bus.rs_val_E;
                op_b <= bus.rt_val_E;
            end
        end
    end

    // Requests arriving while running are ignored: only idle cycles can start or move.
    always_comb begin
        cnt_nxt = (flush || (idle && !start)) ? '0
                : start ? CW'((op_in inside {MD_DIV, MD_DIVU}) ? DIV_CYCLES : MULT_CYCLES)
                : cnt - CW'(1);
        hi_nxt  = (done && we && !flush) ? res[63:32]
                : (mt && op_in == MD_MTHI) ? bus.rs_val_E : hi;
        lo_nxt  = (done && we && !flush) ? res[31:0]
                : (mt && op_in == MD_MTLO) ? bus.rs_val_E : lo;
    end

    always_comb begin
        bus.busy     = start || !idle;
        bus.stall_md = bus.md_use_D && (start || !idle);
        bus.hi       = hi;
        bus.lo       = lo;
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: table, directed and randomized checks of md_sched against a cycle-level model
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       nm;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fl = 1'b0;
    md_sched_if bus();

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MD_FLUSH_EN
        ,
        .md_flush (fl)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, cyc = 0, m_end = -1;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_we = 1'b0, seen_busy = 1'b0;
    string       tag = "init";
    vec_t        tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s at cycle %0d: got %h, expected %h", tag, nm, cyc, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, independent of the RTL datapath.
    task automatic model_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, pr;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        pr = '0;
        p_we = 1'b1;
        case (op)
            3'd1: pr = sa * sb;
            3'd2: pr = ua * ub;
            3'd3: if (b == 0) p_we = 1'b0; else pr = {32'(sa % sb), 32'(sa / sb)};
            3'd4: if (b == 0) p_we = 1'b0; else pr = {32'(ua % ub), 32'(ua / ub)};
            default: p_we = 1'b0;
        endcase
        {p_hi, p_lo} = pr;
    endtask

    // One pipeline cycle: drive, check outputs against the model, advance the model past the edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic u);
        bit run, st, mb;
        bus.md_valid_E = v;
        bus.md_op_E    = op;
        bus.rs_val_E   = a;
        bus.rt_val_E   = b;
        bus.md_use_D   = u;
        #1;
        run = cyc <= m_end;
        st  = v && op >= 3'd1 && op <= 3'd4 && !run;
        mb  = st || run;
        seen_busy = bus.busy;
        chk("busy", 32'(bus.busy), 32'(mb));
        chk("stall_md", 32'(bus.stall_md), 32'(u && mb));
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        if (fl) m_end = -1;
        else begin
            if (run && cyc == m_end && p_we) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            if (st) begin
                model_arith(op, a, b);
                m_end = cyc + ((op >= 3'd3) ? DC : MC);
            end else if (v && !run && op == 3'd5) m_hi = a;
            else if (v && !run && op == 3'd6) m_lo = a;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.md_valid_E = 1'b0;
        bus.md_op_E    = '0;
        bus.rs_val_E   = '0;
        bus.rt_val_E   = '0;
        bus.md_use_D   = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        m_end = -1;
        m_hi  = '0;
        m_lo  = '0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 20));
            1: return -32'($urandom_range(1, 20));
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          nb;
        logic [2:0]  op;
        logic [31:0] a, b;

        tbl[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 6,  "mult_neg"};
        tbl[1]  = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        11, "divu_100_7"};
        tbl[2]  = '{3'd3, 32'h8000_0000, 32'd0,        32'd2,         32'd14,        11, "div_by_zero"};
        tbl[3]  = '{3'd5, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'd14,        0,  "mthi"};
        tbl[4]  = '{3'd6, 32'hCAFE_F00D, 32'd0,        32'h1234_5678, 32'hCAFE_F00D, 0,  "mtlo"};
        tbl[5]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 6,  "multu_max"};
        tbl[6]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 11, "div_neg_dividend"};
        tbl[7]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 11, "div_neg_divisor"};
        tbl[8]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 11, "div_min_m1"};
        tbl[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         6,  "mult_min_min"};
        tbl[10] = '{3'd4, 32'hFFFF_FFFF, 32'd0,        32'h4000_0000, 32'd0,         11, "divu_by_zero"};
        tbl[11] = '{3'd1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 6,  "mult_m1"};
        tbl[12] = '{3'd2, 32'd7,         32'hFFFF_FFFF, 32'd6,         32'hFFFF_FFF9, 6,  "multu_7_max"};

        do_reset();
        tag = "reset_state";
        bus.md_use_D = 1'b1;
        #1;
        chk("busy", 32'(bus.busy), 32'd0);
        chk("stall_md", 32'(bus.stall_md), 32'd0);
        chk("hi", bus.hi, 32'd0);
        chk("lo", bus.lo, 32'd0);

        foreach (tbl[i]) begin
            tag = tbl[i].nm;
            nb = 0;
            step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            if (seen_busy) nb++;
            for (int k = 0; k < 20 && seen_busy; k++) begin
                step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
                if (seen_busy) nb++;
            end
            chk("latency", 32'(nb), 32'(tbl[i].lat));
            chk("final_hi", bus.hi, tbl[i].hi);
            chk("final_lo", bus.lo, tbl[i].lo);
        end

        tag = "run_ignore";
        step(1'b1, 3'd1, 32'd3, 32'd4, 1'b1);
        step(1'b1, 3'd4, 32'd50, 32'd5, 1'b1);
        step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        repeat (6) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("final_hi", bus.hi, 32'd0);
        chk("final_lo", bus.lo, 32'd12);

        tag = "reset_mid";
        step(1'b1, 3'd5, 32'h5555_5555, 32'd0, 1'b0);
        step(1'b1, 3'd1, 32'd5, 32'd7, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        do_reset();
        bus.md_use_D = 1'b1;
        #1;
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("stall_after", 32'(bus.stall_md), 32'd0);
        chk("hi_after", bus.hi, 32'd0);
        chk("lo_after", bus.lo, 32'd0);
        repeat (8) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        chk("final_hi", bus.hi, 32'd0);
        chk("final_lo", bus.lo, 32'd0);

`ifdef MD_FLUSH_EN
        tag = "flush";
        step(1'b1, 3'd5, 32'hAA, 32'd0, 1'b0);
        step(1'b1, 3'd6, 32'hAA, 32'd0, 1'b0);
        step(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        fl = 1'b1;
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        fl = 1'b0;
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        chk("busy_after", 32'(seen_busy), 32'd0);
        fl = 1'b1;
        step(1'b1, 3'd5, 32'hBEEF, 32'd0, 1'b0);
        fl = 1'b0;
        repeat (12) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("final_hi", bus.hi, 32'hAA);
        chk("final_lo", bus.lo, 32'hAA);
`endif

        tag = "random";
        for (int i = 0; i < 600; i++) begin
            op = 3'($urandom_range(0, 6));
            a  = pick();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
`ifdef MD_FLUSH_EN
            fl = ($urandom_range(0, 15) == 0);
`endif
            step($urandom_range(0, 3) != 0, op, a, b, 1'($urandom_range(0, 1)));
        end
        fl = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline: accepts mult/multu/div/divu/mthi/mtlo from the E stage, runs a multi-cycle latency counter, owns the HI/LO registers and raises the D-stage stall whenever a multiply/divide-class instruction would touch HI/LO while an operation is in flight. It sits beside the ALU in E; its stall output is ORed into the pipeline stall with the existing forwarding/hazard logic.

## Interface
- MULT_CYCLES, 5, cycles from acceptance of mult/multu to HI/LO valid (≥1)
- DIV_CYCLES, 10, same for div/divu (≥1)

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low; clears all state on a rising clk edge while low
- md_valid_E  in  1  md_op_E carries a live instruction (low for bubbles/stalled E)
- md_op_E  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- rs_val_E  in  32  forwarded rs operand
- rt_val_E  in  32  forwarded rt operand
- md_use_D  in  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_flush  in  1  present only with MD_FLUSH_EN
- busy  out  1  operation in flight or starting this cycle
- stall_md  out  1  stall request to D
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE (cnt==0), RUN (cnt!=0). cnt is a counter sized for max(MULT_CYCLES, DIV_CYCLES).
- start = md_valid_E & op∈{1..4} & IDLE. On the start edge: capture rs/rt into op_a/op_b, capture op into op_r, cnt←N (MULT_CYCLES or DIV_CYCLES).
- In RUN: cnt decrements every cycle; on the edge where cnt goes 1→0, HI/LO are written from the captured operands.
- mult: {HI,LO}=signed a*b (64-bit). multu: unsigned. div: LO=signed a/b, HI=signed a%b (remainder takes dividend's sign). divu: unsigned.
- Divide with b==0: full DIV_CYCLES latency, HI/LO left unchanged.
- mthi/mtlo with md_valid_E in IDLE: HI (or LO)←rs_val_E at that edge, no busy.
- busy = start | RUN. stall_md = md_use_D & busy.
- Any md op presented in RUN is a protocol violation (prevented by stall_md); it is ignored and the running op is unaffected.
- Reset: cnt=0, HI=LO=0, op_a=op_b=0; outputs busy=0, stall_md=0, hi=0, lo=0. Reset mid-operation abandons the op with no HI/LO write.

## Timing
- Start accepted in cycle t: busy high cycles t..t+N; HI/LO updated at the end of cycle t+N; from cycle t+N+1 hi/lo show new values and busy=0.
- mfhi in D during cycle t+N stalls; released in t+N+1 and reads the new value via hi/lo in E.
- mthi/mtlo: value visible on hi/lo the cycle after the edge.
- No combinational path from rs_val_E/rt_val_E to any output.

## Configuration
- MD_FLUSH_EN defined: md_flush port present. md_flush high at an edge forces cnt←0, suppresses the pending HI/LO write, cancels a same-cycle start or mthi/mtlo; busy=0 the next cycle; HI/LO keep pre-op values. Takes priority over everything except reset.
- Undefined: no md_flush port; every accepted operation completes.

## Structure
- Package md_pkg: op encodings (MD_NONE..MD_MTLO), default MULT_CYCLES/DIV_CYCLES constants.
- One sub-module md_arith: combinational, takes op_r/op_a/op_b, returns 64-bit {hi,lo} result and a write-enable (low for divide-by-zero).

## Test plan
- mult rs=0xFFFFFFFE, rt=3 at t -> busy t..t+5; at t+6, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu 100/7 then md_use_D high from t+1 -> stall_md high t+1..t+10, low t+11; lo=14, hi=2.
- div 0x80000000/0 -> 10-cycle busy, hi/lo unchanged from prior values.
- mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never high.
- reset low at t+2 of a mult -> next cycle busy=0, hi=lo=0, no later write.
- MD_FLUSH_EN: md_flush at t+3 of div with hi=lo=0xAA -> busy=0 at t+4, hi/lo stay 0xAA.
